// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback and
// MDU results held in a two-entry FIFO. Includes WAW kill and a bounded-starvation stall.
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_valid,
  input  logic [1:0]  wb_sel,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_read_data,
  input  logic [31:0] wb_alu_result,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_data,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);
  localparam int         DEPTH = 2;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [DEPTH-1:0]       alive_q, alive_d;
  logic [DEPTH-1:0][4:0]  ent_rd_q, ent_rd_d;
  logic [DEPTH-1:0][31:0] ent_data_q, ent_data_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic [1:0]             count_q, count_d;
  logic [3:0]             starve_q, starve_d;
  logic                   ready_q, ready_d;
  logic                   rf_we_q, rf_we_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [31:0]            rf_wdata_q, rf_wdata_d;

  logic        head_valid;
  logic        head_live;
  logic        pipe_live;
  logic        stall;
  logic        grant_head;
  logic        grant_pipe;
  logic        pop;
  logic        push;
  logic        push_alive;
  logic [31:0] pipe_data;

  always_comb begin
    head_valid = (count_q != 2'd0);
    head_live  = head_valid && alive_q[rd_ptr_q];
    pipe_live  = wb_valid && (wb_sel != 2'b11) && (wb_rd != 5'd0);
    stall      = head_live && (starve_q >= LIMIT);
    grant_head = head_live && (stall || !pipe_live);
    grant_pipe = pipe_live && !stall;
    // A dead head leaves without touching the port
    pop        = head_valid && (!alive_q[rd_ptr_q] || grant_head);
    push       = mdu_valid && ready_q;
    // The pipeline instruction is younger, so a same-cycle push to its rd is stale
    push_alive = (mdu_rd != 5'd0) && !(grant_pipe && (mdu_rd == wb_rd));
  end

  always_comb begin
    case (wb_sel)
      2'b00:   pipe_data = wb_alu_result;
      2'b01:   pipe_data = wb_read_data;
      2'b10:   pipe_data = wb_pc + 32'd4;
      default: pipe_data = wb_alu_result;
    endcase
  end

  always_comb begin
    alive_d    = alive_q;
    ent_rd_d   = ent_rd_q;
    ent_data_d = ent_data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_pipe && (ent_rd_q[i] == wb_rd)) begin
        alive_d[i] = 1'b0;
      end
      if (pop && (rd_ptr_q == 1'(i))) begin
        alive_d[i] = 1'b0;
      end
      if (push && (wr_ptr_q == 1'(i))) begin
        alive_d[i]    = push_alive;
        ent_rd_d[i]   = mdu_rd;
        ent_data_d[i] = mdu_data;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
    // Ready follows the post-update occupancy, so a pop never enables a same-cycle push
    ready_d = (count_d != 2'd2);
  end

  always_comb begin
    starve_d = 4'd0;
    if (pop) begin
      starve_d = 4'd0;
    end else if (head_live) begin
      starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_head) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = ent_rd_q[rd_ptr_q];
      rf_wdata_d = ent_data_q[rd_ptr_q];
    end else if (grant_pipe) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = pipe_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q    <= '0;
      ent_rd_q   <= '0;
      ent_data_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      starve_q   <= 4'd0;
      ready_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      alive_q    <= alive_d;
      ent_rd_q   <= ent_rd_d;
      ent_data_q <= ent_data_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      ready_q    <= ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign mdu_ready  = ready_q;
  assign pipe_stall = stall;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_regfile_wb_arbiter;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_valid = 1'b0;
  logic [1:0]  wb_sel = 2'b11;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_pc = 32'd0;
  logic [31:0] wb_read_data = 32'd0;
  logic [31:0] wb_alu_result = 32'd0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = 5'd0;
  logic [31:0] mdu_data = 32'd0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_rd(wb_rd), .wb_pc(wb_pc),
    .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: MDU results as a queue in arrival order
  typedef struct {
    bit          alive;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  int          m_starve = 0;
  bit          m_seen = 1'b0;
  bit          e_we = 1'b0;
  logic [4:0]  e_addr = 5'd0;
  logic [31:0] e_data = 32'd0;

  function automatic logic [31:0] pipe_value(input logic [1:0] sel, input logic [31:0] pc,
                                             input logic [31:0] rdata, input logic [31:0] alu);
    if (sel == 2'b01) return rdata;
    if (sel == 2'b10) return pc + 32'd4;
    return alu;
  endfunction

  always @(negedge clk) begin : model
    bit   head_live, stall_m, pipe_live, can_push, g_head, g_pipe, pop;
    ent_t ne;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
      m_seen   = 1'b0;
      e_we     = 1'b0;
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      check("rst_rf_wdata", rf_wdata, 32'd0);
      check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      check("rst_mdu_ready", 32'(mdu_ready), 32'd0);
    end else begin
      head_live = (mq.size() > 0) && mq[0].alive;
      stall_m   = head_live && (m_starve >= int'(LIMIT));
      check("cyc_rf_we", 32'(rf_we), 32'(e_we));
      if (e_we) begin
        check("cyc_rf_waddr", 32'(rf_waddr), 32'(e_addr));
        check("cyc_rf_wdata", rf_wdata, e_data);
      end
      check("cyc_pipe_stall", 32'(pipe_stall), 32'(stall_m));
      check("cyc_mdu_ready", 32'(mdu_ready), 32'(m_seen && (mq.size() < 2)));

      // Next clock edge
      pipe_live = wb_valid && (wb_sel != 2'b11) && (wb_rd != 5'd0);
      can_push  = m_seen && (mq.size() < 2);
      g_head    = head_live && (stall_m || !pipe_live);
      g_pipe    = pipe_live && !stall_m;
      pop       = (mq.size() > 0) && (!mq[0].alive || g_head);
      e_we = 1'b0;
      if (g_head) begin
        e_we = 1'b1; e_addr = mq[0].rd; e_data = mq[0].data;
      end else if (g_pipe) begin
        e_we = 1'b1; e_addr = wb_rd;
        e_data = pipe_value(wb_sel, wb_pc, wb_read_data, wb_alu_result);
      end
      if (pop) m_starve = 0;
      else if (head_live && (m_starve < int'(LIMIT))) m_starve++;
      if (g_pipe) foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].alive = 1'b0;
      if (pop) void'(mq.pop_front());
      if (mdu_valid && can_push) begin
        ne.alive = (mdu_rd != 5'd0) && !(g_pipe && (mdu_rd == wb_rd));
        ne.rd    = mdu_rd;
        ne.data  = mdu_data;
        mq.push_back(ne);
      end
      m_seen = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                        input logic [31:0] pc, input logic [31:0] rdata, input logic [31:0] alu);
    wb_valid = v; wb_sel = sel; wb_rd = rd; wb_pc = pc; wb_read_data = rdata; wb_alu_result = alu;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] data);
    mdu_valid = v; mdu_rd = rd; mdu_data = data;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("por_rf_we", 32'(rf_we), 32'd0);
    check("por_mdu_ready", 32'(mdu_ready), 32'd0);
    check("por_pipe_stall", 32'(pipe_stall), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check("ready_after_reset", 32'(mdu_ready), 32'd1);

    // Pipeline only
    set_wb(1, 2'b10, 5'd5, 32'h100, 32'h0, 32'h0);
    cyc();
    check("pc4_we", 32'(rf_we), 32'd1);
    check("pc4_addr", 32'(rf_waddr), 32'd5);
    check("pc4_data", rf_wdata, 32'h104);
    set_wb(1, 2'b11, 5'd6, 32'h200, 32'h0, 32'h66);
    cyc();
    check("sel11_we", 32'(rf_we), 32'd0);
    set_wb(1, 2'b00, 5'd0, 32'h0, 32'h0, 32'h55);
    cyc();
    check("rd0_we", 32'(rf_we), 32'd0);
    set_wb(1, 2'b00, 5'd8, 32'h0, 32'h0, 32'h1234);
    cyc();
    check("alu_data", rf_wdata, 32'h1234);
    set_wb(1, 2'b01, 5'd9, 32'h0, 32'hCAFE, 32'h0);
    cyc();
    check("load_data", rf_wdata, 32'hCAFE);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);

    // MDU into idle port
    set_mdu(1, 5'd7, 32'hDEAD);
    cyc();
    set_mdu(0, 5'd0, 32'h0);
    cyc();
    check("mdu_idle_we", 32'(rf_we), 32'd1);
    check("mdu_idle_addr", 32'(rf_waddr), 32'd7);
    check("mdu_idle_data", rf_wdata, 32'hDEAD);
    check("mdu_idle_ready", 32'(mdu_ready), 32'd1);

    // Starvation
    set_wb(1, 2'b00, 5'd9, 32'h0, 32'h0, 32'h900);
    set_mdu(1, 5'd3, 32'h333);
    cyc();
    set_mdu(0, 5'd0, 32'h0);
    check("starve_no_stall_0", 32'(pipe_stall), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("starve_pipe_addr", 32'(rf_waddr), 32'd9);
    end
    check("starve_stall", 32'(pipe_stall), 32'd1);
    cyc();
    check("starve_head_addr", 32'(rf_waddr), 32'd3);
    check("starve_head_data", rf_wdata, 32'h333);
    check("starve_released", 32'(pipe_stall), 32'd0);
    cyc();
    check("starve_resume_addr", 32'(rf_waddr), 32'd9);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);

    // WAW: buffered rd=4 overwritten by pipeline
    set_wb(1, 2'b00, 5'd10, 32'h0, 32'h0, 32'hA10);
    set_mdu(1, 5'd4, 32'h444);
    cyc();
    set_mdu(0, 5'd0, 32'h0);
    set_wb(1, 2'b00, 5'd4, 32'h0, 32'h0, 32'hA4);
    cyc();
    check("waw_addr", 32'(rf_waddr), 32'd4);
    check("waw_data", rf_wdata, 32'hA4);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("waw_dead_pop_we", 32'(rf_we), 32'd0);
    cyc();
    check("waw_idle_we", 32'(rf_we), 32'd0);

    // WAW: same-cycle push killed
    set_wb(1, 2'b00, 5'd12, 32'h0, 32'h0, 32'hBB);
    set_mdu(1, 5'd12, 32'hC12);
    cyc();
    check("waw_push_data", rf_wdata, 32'hBB);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);
    set_mdu(0, 5'd0, 32'h0);
    cyc();
    check("waw_push_pop_we", 32'(rf_we), 32'd0);
    cyc();
    check("waw_push_idle_we", 32'(rf_we), 32'd0);

    // Full FIFO under continuous pipeline traffic
    set_wb(1, 2'b00, 5'd11, 32'h0, 32'h0, 32'hB00);
    set_mdu(1, 5'd13, 32'hD1);
    cyc();
    set_mdu(1, 5'd14, 32'hD2);
    cyc();
    check("full_ready0_a", 32'(mdu_ready), 32'd0);
    set_mdu(1, 5'd15, 32'hD3);
    cyc();
    check("full_ready0_b", 32'(mdu_ready), 32'd0);
    cyc();
    check("full_no_stall_yet", 32'(pipe_stall), 32'd0);
    cyc();
    check("full_stall", 32'(pipe_stall), 32'd1);
    check("full_ready0_c", 32'(mdu_ready), 32'd0);
    cyc();
    check("full_drain1_addr", 32'(rf_waddr), 32'd13);
    check("full_drain1_data", rf_wdata, 32'hD1);
    check("full_ready_back", 32'(mdu_ready), 32'd1);
    cyc();
    set_mdu(0, 5'd0, 32'h0);
    check("full_pipe_addr", 32'(rf_waddr), 32'd11);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    check("full_drain2_addr", 32'(rf_waddr), 32'd14);
    check("full_drain2_data", rf_wdata, 32'hD2);
    cyc();
    check("full_drain3_addr", 32'(rf_waddr), 32'd15);
    check("full_drain3_data", rf_wdata, 32'hD3);

    // Reset mid-flight with two entries buffered
    set_wb(1, 2'b00, 5'd16, 32'h0, 32'h0, 32'h1600);
    set_mdu(1, 5'd17, 32'h1717);
    cyc();
    set_mdu(1, 5'd18, 32'h1818);
    cyc();
    set_mdu(0, 5'd0, 32'h0);
    check("mid_full", 32'(mdu_ready), 32'd0);
    check("mid_pipe_we", 32'(rf_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_we", 32'(rf_we), 32'd0);
    check("mid_rst_addr", 32'(rf_waddr), 32'd0);
    check("mid_rst_data", rf_wdata, 32'd0);
    check("mid_rst_ready", 32'(mdu_ready), 32'd0);
    check("mid_rst_stall", 32'(pipe_stall), 32'd0);
    set_wb(0, 2'b11, 5'd0, 32'h0, 32'h0, 32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("post_rst_no_write", 32'(rf_we), 32'd0);
    end
    check("post_rst_ready", 32'(mdu_ready), 32'd1);

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
